// File: rtl/uart_tx_cfg_pkg.sv
// Shared types for the configurable UART transmitter: FSM state encoding and parity selector values.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake, per-frame configuration and serial-side status of the UART transmitter.
// The master modport is the word producer; the slave modport is the transmitter itself.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]         P_DATA;
    logic                          DATA_VALID;
    logic                          DATA_READY;
    logic [$clog2(DATA_WIDTH)-1:0] DATA_LEN;
    logic                          PAR_EN;
    logic                          PAR_TYP;
    logic                          STOP2;
    logic [PRESC_WIDTH-1:0]        PRESCALE;
    logic                          TX_OUT;
    logic                          BUSY;
    logic                          TX_DONE;

    modport master (
        output P_DATA, DATA_VALID, DATA_LEN, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        input  DATA_READY, TX_OUT, BUSY, TX_DONE
    );

    modport slave (
        input  P_DATA, DATA_VALID, DATA_LEN, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        output DATA_READY, TX_OUT, BUSY, TX_DONE
    );
endinterface

// File: rtl/uart_tx_cfg_fifo.sv
// Synchronous power-of-two FIFO with full/empty flags, used as the optional input buffer.
// A push is refused while full, even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             doPush, doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (doPush) wptr_d = wptr_q + (AW+1)'(1);
        if (doPop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with internal baud prescaler.
// Defining UART_TX_FIFO_EN places a FIFO_DEPTH-entry input FIFO in front of the FSM.
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_cfg_if.slave bus
);
    localparam int LEN_W = $clog2(DATA_WIDTH);

    state_e                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] baud_q, baud_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [LEN_W-1:0]       bitCnt_q, bitCnt_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   parEn_q, parEn_d;
    logic                   parBit_q, parBit_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;

    logic                   finalStop, lastStop, canLoad, load;
    logic                   srcValid;
    logic [DATA_WIDTH-1:0]  srcData;
    logic [PRESC_WIDTH-1:0] prescNew;
    logic                   parNew;

    assign finalStop = (state_q == STOP2) || ((state_q == STOP1) && !stop2_q);
    assign lastStop  = finalStop && (baud_q == '0);
    assign canLoad   = (state_q == IDLE) || lastStop;
    assign load      = canLoad && srcValid && !RST;

`ifdef UART_TX_FIFO_EN
    logic fifoFull, fifoEmpty;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (bus.DATA_VALID && bus.DATA_READY),
        .din_i   (bus.P_DATA),
        .pop_i   (load),
        .dout_o  (srcData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign srcValid       = !fifoEmpty;
    assign bus.DATA_READY = !fifoFull && !RST;
`else
    assign srcValid       = bus.DATA_VALID;
    assign srcData        = bus.P_DATA;
    assign bus.DATA_READY = canLoad && !RST;
`endif

    // PRESCALE of 0 or 1 both give one cycle per bit, so the reload value saturates at 0.
    assign prescNew = (bus.PRESCALE > PRESC_WIDTH'(1)) ? (bus.PRESCALE - PRESC_WIDTH'(1)) : '0;

    always_comb begin
        parNew = (bus.PAR_TYP == PAR_ODD);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i <= int'(bus.DATA_LEN)) parNew = parNew ^ srcData[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        presc_d  = presc_q;
        bitCnt_d = bitCnt_q;
        len_d    = len_q;
        shift_d  = shift_q;
        parEn_d  = parEn_q;
        parBit_d = parBit_q;
        stop2_d  = stop2_q;
        tx_d     = 1'b1;

        case (state_q)
            IDLE: baud_d = '0;
            START: begin
                if (baud_q == '0) begin
                    state_d  = DATA;
                    baud_d   = presc_q;
                    bitCnt_d = '0;
                end else begin
                    baud_d = baud_q - PRESC_WIDTH'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = presc_q;
                    if (bitCnt_q == len_q) begin
                        state_d = parEn_q ? PARITY : STOP1;
                    end else begin
                        bitCnt_d = bitCnt_q + LEN_W'(1);
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - PRESC_WIDTH'(1);
                end
            end
            PARITY: begin
                if (baud_q == '0) begin
                    state_d = STOP1;
                    baud_d  = presc_q;
                end else begin
                    baud_d = baud_q - PRESC_WIDTH'(1);
                end
            end
            STOP1: begin
                if (baud_q == '0) begin
                    state_d = stop2_q ? STOP2 : IDLE;
                    baud_d  = stop2_q ? presc_q : '0;
                end else begin
                    baud_d = baud_q - PRESC_WIDTH'(1);
                end
            end
            STOP2: begin
                if (baud_q == '0) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q - PRESC_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A load overrides the idle/frame-end decision so frames can run back-to-back.
        if (load) begin
            state_d  = START;
            baud_d   = prescNew;
            presc_d  = prescNew;
            bitCnt_d = '0;
            len_d    = bus.DATA_LEN;
            shift_d  = srcData;
            parEn_d  = bus.PAR_EN;
            parBit_d = parNew;
            stop2_d  = bus.STOP2;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parBit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            presc_q  <= '0;
            bitCnt_q <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            parEn_q  <= 1'b0;
            parBit_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            presc_q  <= presc_d;
            bitCnt_q <= bitCnt_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            parEn_q  <= parEn_d;
            parBit_q <= parBit_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
        end
    end

    assign bus.TX_OUT  = tx_q;
    assign bus.BUSY    = (state_q != IDLE);
    assign bus.TX_DONE = lastStop;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a cycle-stream model of the serial line checked every cycle,
// plus literal expectations; builds with or without UART_TX_FIFO_EN.
module tb_uart_tx_cfg;
    localparam int DW = 8;
    localparam int PW = 16;
    localparam int FD = 4;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO = 1'b1;
    localparam int LAT  = 1;
`else
    localparam bit FIFO = 1'b0;
    localparam int LAT  = 0;
`endif

    typedef struct packed {
        logic tx;
        logic done;
    } cyc_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       checkEn = 1'b0;
    int         total = 0;
    int         bad = 0;
    cyc_t       stream[$];
    logic [7:0] pending[$];
    logic       capt[64];
    int         busyCnt;
    int         doneAt;

    uart_tx_cfg_if #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) bus ();

    uart_tx_cfg #(
        .DATA_WIDTH  (DW),
        .PRESC_WIDTH (PW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expands one frame into the per-cycle line levels it must produce.
    task automatic appendFrame(input logic [7:0] d, input int len, input logic pe, input logic pt,
                               input logic s2, input int presc);
        logic bits[$];
        logic par;
        int   p;
        p   = (presc < 1) ? 1 : presc;
        par = pt;
        bits.push_back(1'b0);
        for (int i = 0; i <= len; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < p; c++)
                stream.push_back('{tx: bits[b], done: (b == bits.size() - 1) && (c == p - 1)});
    endtask

    always @(posedge CLK) begin
        logic       canLoad, rdy, hs;
        logic [7:0] w;
        canLoad = (stream.size() == 0) || stream[0].done;
        rdy     = (FIFO ? (pending.size() < FD) : canLoad) && !RST;
        hs      = bus.DATA_VALID && rdy;
        if (RST) begin
            stream.delete();
            pending.delete();
        end else begin
            if (stream.size() > 0) void'(stream.pop_front());
            if (FIFO) begin
                if (canLoad && pending.size() > 0) begin
                    w = pending.pop_front();
                    appendFrame(w, int'(bus.DATA_LEN), bus.PAR_EN, bus.PAR_TYP, bus.STOP2, int'(bus.PRESCALE));
                end
                if (hs) pending.push_back(bus.P_DATA);
            end else if (hs) begin
                appendFrame(bus.P_DATA, int'(bus.DATA_LEN), bus.PAR_EN, bus.PAR_TYP, bus.STOP2, int'(bus.PRESCALE));
            end
        end
    end

    always @(negedge CLK) begin
        logic eTx, eBusy, eDone, eRdy;
        #1;
        if (checkEn) begin
            eBusy = stream.size() > 0;
            eTx   = eBusy ? stream[0].tx : 1'b1;
            eDone = eBusy && stream[0].done;
            eRdy  = (FIFO ? (pending.size() < FD) : (!eBusy || stream[0].done)) && !RST;
            checkOutput("tx_out", 32'(bus.TX_OUT), 32'(eTx));
            checkOutput("busy", 32'(bus.BUSY), 32'(eBusy));
            checkOutput("tx_done", 32'(bus.TX_DONE), 32'(eDone));
            checkOutput("data_ready", 32'(bus.DATA_READY), 32'(eRdy));
        end
    end

    // Offers one word, waits for its handshake, then records ncap cycles from the frame start.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] len, input logic pe,
                                 input logic pt, input logic s2, input logic [15:0] presc, input int ncap);
        int guard;
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.DATA_LEN   = len;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.STOP2      = s2;
        bus.PRESCALE   = presc;
        bus.DATA_VALID = 1'b1;
        #1;
        guard = 0;
        while (!bus.DATA_READY && guard < 200) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard >= 200) checkOutput("ready_timeout", 32'(bus.DATA_READY), 32'd1);
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        repeat (LAT) @(negedge CLK);
        busyCnt = 0;
        doneAt  = -1;
        for (int k = 0; k < ncap; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            capt[k] = bus.TX_OUT;
            if (bus.BUSY) busyCnt++;
            if (bus.TX_DONE) doneAt = k;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [9:0] expA5;
        logic [9:0] exp5A;
        bit         second;
        int         pushed, busyCycles, g;
        bit         lowSeen;

        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.DATA_LEN   = 3'd7;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.STOP2      = 1'b0;
        bus.PRESCALE   = 16'd4;

        @(posedge CLK);
        @(negedge CLK);
        checkEn = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_tx", 32'(bus.TX_OUT), 32'd1);
        checkOutput("rst_busy", 32'(bus.BUSY), 32'd0);
        checkOutput("rst_done", 32'(bus.TX_DONE), 32'd0);
        checkOutput("rst_ready", 32'(bus.DATA_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] basic frame 0xA5, prescale 4");
        expA5 = 10'b11_1010_0101 ^ 10'b00_1111_1111 ^ 10'b00_0101_0101;
        expA5 = 10'b1101001010;
        applyStimulus(8'hA5, 3'd7, 1'b0, 1'b0, 1'b0, 16'd4, 44);
        for (int i = 0; i < 40; i++) checkOutput($sformatf("a5_cycle%0d", i), 32'(capt[i]), 32'(expA5[i / 4]));
        checkOutput("a5_busy_len", 32'(busyCnt), 32'd40);
        checkOutput("a5_done_at", 32'(doneAt), 32'd39);

        $display("[TB] parity variants, prescale 1");
        applyStimulus(8'h03, 3'd7, 1'b1, 1'b0, 1'b0, 16'd1, 12);
        checkOutput("par_even_bit", 32'(capt[9]), 32'd0);
        checkOutput("par_even_len", 32'(busyCnt), 32'd11);
        applyStimulus(8'h03, 3'd7, 1'b1, 1'b1, 1'b0, 16'd1, 12);
        checkOutput("par_odd_bit", 32'(capt[9]), 32'd1);
        applyStimulus(8'h03, 3'd7, 1'b1, 1'b1, 1'b1, 16'd0, 14);
        checkOutput("stop2_len", 32'(busyCnt), 32'd12);
        checkOutput("stop2_bit1", 32'(capt[10]), 32'd1);
        checkOutput("stop2_bit2", 32'(capt[11]), 32'd1);
        checkOutput("stop2_done_at", 32'(doneAt), 32'd11);

        $display("[TB] short word, 5 data bits");
        applyStimulus(8'hFF, 3'd4, 1'b1, 1'b0, 1'b0, 16'd1, 10);
        checkOutput("short_start", 32'(capt[0]), 32'd0);
        for (int i = 1; i <= 5; i++) checkOutput($sformatf("short_data%0d", i - 1), 32'(capt[i]), 32'd1);
        checkOutput("short_parity", 32'(capt[6]), 32'd1);
        checkOutput("short_len", 32'(busyCnt), 32'd8);
        checkOutput("short_done_at", 32'(doneAt), 32'd7);

        $display("[TB] back-to-back 0x11, 0x22, prescale 2");
        @(negedge CLK);
        bus.P_DATA     = 8'h11;
        bus.DATA_LEN   = 3'd7;
        bus.PAR_EN     = 1'b0;
        bus.STOP2      = 1'b0;
        bus.PRESCALE   = 16'd2;
        bus.DATA_VALID = 1'b1;
        #1;
        g = 0;
        while (!bus.DATA_READY && g < 200) begin
            @(negedge CLK);
            #1;
            g++;
        end
        @(negedge CLK);
        bus.P_DATA = 8'h22;
        second  = 1'b0;
        busyCnt = 0;
        doneAt  = -1;
        for (int k = 0; k < 44; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                if (second) bus.DATA_VALID = 1'b0;
            end
            #1;
            capt[k] = bus.TX_OUT;
            if (bus.BUSY) busyCnt++;
            if (bus.TX_DONE) doneAt = k;
            if (!second && bus.DATA_READY) second = 1'b1;
        end
        bus.DATA_VALID = 1'b0;
        checkOutput("b2b_second_taken", 32'(second), 32'd1);
        checkOutput("b2b_stop_before", 32'(capt[19 + LAT]), 32'd1);
        checkOutput("b2b_start2", 32'(capt[20 + LAT]), 32'd0);
        checkOutput("b2b_d0", 32'(capt[22 + LAT]), 32'd0);
        checkOutput("b2b_d1", 32'(capt[24 + LAT]), 32'd1);
        checkOutput("b2b_busy", 32'(busyCnt), 32'd40);
        checkOutput("b2b_done_at", 32'(doneAt), 32'(39 + LAT));

        $display("[TB] reset mid-frame");
        applyStimulus(8'h5A, 3'd7, 1'b0, 1'b0, 1'b0, 16'd4, 14);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        checkOutput("midrst_tx", 32'(bus.TX_OUT), 32'd1);
        checkOutput("midrst_busy", 32'(bus.BUSY), 32'd0);
        checkOutput("midrst_ready", 32'(bus.DATA_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        exp5A = 10'b1010110100;
        applyStimulus(8'h5A, 3'd7, 1'b0, 1'b0, 1'b0, 16'd4, 44);
        for (int i = 0; i < 40; i++) checkOutput($sformatf("5a_cycle%0d", i), 32'(capt[i]), 32'(exp5A[i / 4]));
        checkOutput("5a_busy_len", 32'(busyCnt), 32'd40);

`ifdef UART_TX_FIFO_EN
        $display("[TB] fifo burst 0x01..0x06, prescale 2");
        pushed     = 0;
        busyCycles = 0;
        lowSeen    = 1'b0;
        g          = 0;
        @(negedge CLK);
        bus.PRESCALE   = 16'd2;
        bus.P_DATA     = 8'h01;
        bus.DATA_VALID = 1'b1;
        while (pushed < 6 && g < 300) begin
            #1;
            if (bus.BUSY) busyCycles++;
            if (bus.DATA_READY) pushed++;
            else lowSeen = 1'b1;
            @(negedge CLK);
            g++;
            if (pushed < 6) bus.P_DATA = 8'(pushed + 1);
            else bus.DATA_VALID = 1'b0;
        end
        #1;
        while (bus.BUSY && g < 600) begin
            busyCycles++;
            @(negedge CLK);
            #1;
            g++;
        end
        checkOutput("fifo_pushed", 32'(pushed), 32'd6);
        checkOutput("fifo_full_seen", 32'(lowSeen), 32'd1);
        checkOutput("fifo_busy", 32'(busyCycles), 32'd120);
`else
        pushed     = 0;
        busyCycles = 0;
        lowSeen    = 1'b0;
`endif

        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter. It accepts parallel words over a valid/ready handshake and serialises them LSB-first, framed with a start bit, optional parity and one or two stop bits. It has an internal baud prescaler, so it runs directly on the system clock with no external tick. It sits between the register file / system controller and the TX pin, next to the UART receiver.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame.
- PRESC_WIDTH, 16: width of the PRESCALE input.
- FIFO_DEPTH, 4: input FIFO depth. Must be a power of two, at least 2. Used only when UART_TX_FIFO_EN is defined.
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  word to send. Bit 0 is sent first.
- DATA_VALID  in  1  P_DATA is offered.
- DATA_READY  out  1  block can accept a word. A transfer happens on any edge where DATA_VALID and DATA_READY are both 1.
- DATA_LEN  in  $clog2(DATA_WIDTH)  number of data bits minus 1 (7 means 8 bits).
- PAR_EN  in  1  parity bit is inserted.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  in  PRESC_WIDTH  CLK cycles per bit. 0 and 1 both mean 1.
- TX_OUT  out  1  serial line, registered, idles high.
- BUSY  out  1  a frame is in progress (state is not IDLE).
- TX_DONE  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Per-frame latching:
  - On word load, the block latches the data, DATA_LEN, PAR_EN, PAR_TYP, STOP2 and PRESCALE.
  - Changing these inputs mid-frame has no effect on the current frame.
- Parity is computed at load over bits [DATA_LEN:0] only:
  - even parity: parity bit = XOR of those bits;
  - odd parity: parity bit = inverted XOR of those bits;
  - bits above DATA_LEN are ignored, both for sending and for parity.
- Baud counter is loaded with the effective prescale minus 1 on every bit entry and counts down. A bit ends when the counter reaches 0.
- State transitions:
  - IDLE → START on word load.
  - START → DATA.
  - DATA shifts one bit per bit period. After DATA_LEN+1 bits, go to PARITY if PAR_EN, else STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if STOP2 was latched; otherwise the frame ends.
- Frame end:
  - If a word is available in the last cycle of the final stop bit, it loads and the next edge enters START. Frames run back-to-back with no idle cycle.
  - Otherwise the next state is IDLE.
- DATA_READY without FIFO: 1 in IDLE, and in the last cycle of the final stop bit; 0 otherwise.
- TX_OUT per state: IDLE 1, START 0, DATA = current shift bit, PARITY = parity bit, STOP states 1.
- Reset, including mid-frame: on the next edge TX_OUT = 1, BUSY = 0, TX_DONE = 0, state = IDLE, counters = 0, FIFO emptied. DATA_READY is forced to 0 while RST is high.

## Timing
- Reset values: TX_OUT 1, BUSY 0, TX_DONE 0, DATA_READY 0 (during reset).
- Latency, no FIFO: handshake at edge N → TX_OUT low from N+1.
- Latency, with FIFO: handshake at edge N → TX_OUT low from N+2.
- Each bit lasts exactly max(PRESCALE,1) cycles.
- Frame length in cycles = (2 + DATA_LEN + PAR_EN + 1 + STOP2) × max(PRESCALE,1).
- BUSY is high for exactly one frame length per isolated frame. It stays high continuously across back-to-back frames.
- TX_DONE is high for one cycle per frame and coincides with the final cycle of the stop bit.

## Configuration
- Macro: UART_TX_FIFO_EN.
- Defined:
  - a FIFO_DEPTH-entry input FIFO sits in front of the FSM;
  - DATA_READY = FIFO not full; a full FIFO rejects the push even when a pop happens in the same cycle;
  - the FSM pops the head when the FIFO is non-empty and the FSM is in IDLE or the last cycle of the final stop bit;
  - words go out in push order.
- Undefined: no FIFO; DATA_READY behaves as described in Operation; the port list is identical.

## Structure
- Package uart_tx_pkg holds:
  - the state enum (IDLE…STOP2);
  - PAR_EVEN = 0, PAR_ODD = 1.
- Sub-module uart_tx_fifo, a synchronous FIFO with full and empty flags, instantiated only under UART_TX_FIFO_EN.

## Test plan
- Basic frame: PRESCALE=4, DATA_LEN=7, PAR_EN=0, STOP2=0, P_DATA=0xA5 pulsed once → TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. BUSY is high 40 cycles. TX_DONE pulses at cycle 40.
- Parity and stop bits: PRESCALE=1, P_DATA=0x03, PAR_EN=1:
  - PAR_TYP=0 → parity bit 0;
  - PAR_TYP=1 → parity bit 1;
  - add STOP2=1 → frame is 12 cycles with two high stop bits.
- Short word: DATA_LEN=4, P_DATA=0xFF, even parity → exactly five 1 data bits, then parity 1. Frame is 8 bits.
- Back-to-back: DATA_VALID held with 0x11 then 0x22, PRESCALE=2 → the second start bit immediately follows the first stop bit, with no high gap. BUSY never drops.
- Reset mid-frame: RST asserted in the third data bit → TX_OUT=1 and BUSY=0 next edge. The next frame (0x5A) is bit-exact.
- FIFO build (UART_TX_FIFO_EN, FIFO_DEPTH=4, PRESCALE=2): push 0x01..0x06 continuously → DATA_READY drops when the FIFO is full. All six words are sent in order with no gaps.
